iterative_shift_controller: RTL and testbench

- Multi-cycle controller that sequences a fixed-stride shift datapath to perform a variable-amount shift of an N-bit operand.
- Each cycle the datapath shifts the working register by either STEP bits or 1 bit; the controller chooses the stride, counts the remaining amount and handles the valid/ready handshakes.
- Sits between an operand producer (upstream) and a result consumer (downstream) in the arithmetic/pipelining exercises. It is an area-cheap replacement for a full barrel shifter.

---
 rtl/iterative_shift_controller.sv | 163 ++++++++++++++++
 tb/tb_iterative_shift_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/iterative_shift_controller.sv
// -----------------------------------------------------------------------------
// iterative_shift_controller
//
// Performs a variable-amount shift of an N-bit operand over several cycles by
// reusing a fixed-stride datapath. Each SHIFT cycle moves the working register
// by either STEP bits or 1 bit. The greedy sequence uses STEP while at least
// STEP bits remain, then finishes with single-bit steps. This gives
// floor(a/STEP) + (a mod STEP) shift cycles for an effective amount a.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. up_ready is high only in IDLE. down_valid is
// high only in DONE. down_data is held stable in DONE until the consumer takes
// it. A new request is never accepted in the same cycle that a result leaves.
//
// Optional feature macro: ITERATIVE_SHIFT_ROTATE_EN
//   When it is defined, up_rotate = 1 rotates in direction up_dir, using an
//   effective amount of up_amount mod N. When it is undefined, up_rotate is
//   ignored and no rotate logic is built.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   up_valid/ready  request handshake
//   up_data         operand (N bits)
//   up_amount       unsigned shift amount (AW bits)
//   up_dir          0 = right, 1 = left
//   up_arith        arithmetic right (sign fill); ignored for left
//   up_rotate       rotate request (only with the rotate macro)
//   down_valid/ready result handshake
//   down_data       result; this is the working register itself
//   busy            high in SHIFT or DONE
//   dbg_state       current FSM state, for observation only
// -----------------------------------------------------------------------------
module iterative_shift_controller #(
  parameter int N    = 8,
  parameter int STEP = 3,
  localparam int AW  = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [AW-1:0] up_amount,
  input  logic          up_dir,
  input  logic          up_arith,
  input  logic          up_rotate,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] rem_q;   // shift bits still to apply
  logic          dir_q;   // latched direction
  logic          fill_q;  // bit that enters on a right shift (sign for arith)

  // Decoded request fields, used only on accept.
  logic          rot_req;
  logic [AW-1:0] eff_amt;
  logic          over;
  logic          fill_bit;

`ifdef ITERATIVE_SHIFT_ROTATE_EN
  logic rot_q;

  always_comb begin
    rot_req = up_rotate;
    eff_amt = rot_req ? (up_amount % AW'(N)) : up_amount;
  end
`else
  wire unused_rotate = up_rotate;

  always_comb begin
    rot_req = 1'b0;
    eff_amt = up_amount;
  end
`endif

  // An arithmetic right shift fills with the operand MSB. A left shift always
  // fills with 0, so fill_bit alone covers every non-rotate case.
  assign fill_bit = up_arith && !up_dir && up_data[N-1] && !rot_req;
  // A plain shift by N or more leaves only fill bits, so skip the iteration.
  assign over     = !rot_req && (up_amount >= AW'(N));

  // One datapath step of s bits on the working register.
  function automatic logic [N-1:0] step_by(input logic [N-1:0] w, input int s);
    logic [2*N-1:0] t;
    t = '0;
`ifdef ITERATIVE_SHIFT_ROTATE_EN
    if (rot_q) begin
      t = {w, w};
      t = dir_q ? (t << s) : (t >> s);
      return dir_q ? t[2*N-1:N] : t[N-1:0];
    end
`endif
    if (dir_q) return w << s;
    t = {{N{fill_q}}, w} >> s;
    return t[N-1:0];
  endfunction

  assign up_ready   = (state == IDLE);
  assign down_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      down_data <= '0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      fill_q    <= 1'b0;
`ifdef ITERATIVE_SHIFT_ROTATE_EN
      rot_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (up_valid) begin
            dir_q  <= up_dir;
            fill_q <= fill_bit;
`ifdef ITERATIVE_SHIFT_ROTATE_EN
            rot_q  <= rot_req;
`endif
            if (over) begin
              down_data <= {N{fill_bit}};
              rem_q     <= '0;
              state     <= DONE;
            end else begin
              down_data <= up_data;
              rem_q     <= eff_amt;
              state     <= (eff_amt == '0) ? DONE : SHIFT;
            end
          end
        end
        SHIFT: begin
          if (rem_q >= AW'(STEP)) begin
            down_data <= step_by(down_data, STEP);
            rem_q     <= rem_q - AW'(STEP);
            if (rem_q == AW'(STEP)) state <= DONE;
          end else begin
            down_data <= step_by(down_data, 1);
            rem_q     <= rem_q - AW'(1);
            if (rem_q == AW'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (down_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shift_controller.sv
module tb_iterative_shift_controller;
  localparam int N    = 8;
  localparam int STEP = 3;
  localparam int AW   = $clog2(N) + 1;
`ifdef ITERATIVE_SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          up_valid, up_ready, up_dir, up_arith, up_rotate;
  logic [N-1:0]  up_data;
  logic [AW-1:0] up_amount;
  logic          down_valid, down_ready, busy;
  logic [N-1:0]  down_data;
  logic [1:0]    dbg_state;

  iterative_shift_controller #(.N(N), .STEP(STEP)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_amount(up_amount), .up_dir(up_dir), .up_arith(up_arith),
    .up_rotate(up_rotate),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] model_data(input logic [N-1:0] d, input int a,
                                              input logic dir, input logic arith,
                                              input logic rot);
    logic [N-1:0] r;
    int sh;
    r = '0;
    if (rot && ROT_EN) begin
      sh = a % N;
      for (int i = 0; i < N; i++)
        r[dir ? (i + sh) % N : (i - sh + N) % N] = d[i];
      return r;
    end
    if (a >= N) return (arith && !dir && d[N-1]) ? '1 : '0;
    if (dir) return d << a;
    if (arith) return $signed(d) >>> a;
    return d >> a;
  endfunction

  function automatic int model_lat(input int a, input logic rot);
    int eff;
    if (rot && ROT_EN) eff = a % N;
    else if (a >= N) return 0;
    else eff = a;
    return eff / STEP + eff % STEP;
  endfunction

  // ---------------- driver ----------------
  task automatic scramble_inputs();
    up_data   = N'($urandom);
    up_amount = AW'($urandom);
    up_dir    = 1'($urandom);
    up_arith  = 1'($urandom);
    up_rotate = 1'($urandom);
  endtask

  task automatic run_op(input logic [N-1:0] d, input int a, input logic dir,
                        input logic arith, input logic rot,
                        input logic [N-1:0] exp_d, input int exp_k, input int hold);
    int cyc;
    logic [N-1:0] e;
    cyc = 0;
    while (!up_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("ready_before_req", 32'(up_ready), 32'd1);
    up_valid  = 1'b1;
    up_data   = d;
    up_amount = AW'(a);
    up_dir    = dir;
    up_arith  = arith;
    up_rotate = rot;
    exp_q.push_back(exp_d);
    @(posedge clk); #1;
    up_valid = 1'b0;
    scramble_inputs();
    cyc = 1;
    while (!down_valid && cyc < 100) begin
      check("busy_in_shift", {30'd0, busy, up_ready}, 32'd2);
      @(posedge clk); #1; cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_k + 1));
    e = exp_q.pop_front();
    check("down_data", 32'(down_data), 32'(e));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_data", 32'(down_data), 32'(e));
      check("hold_flags", {29'd0, down_valid, up_ready, busy}, 32'd5);
    end
    down_ready = 1'b1;
    @(posedge clk); #1;
    down_ready = 1'b0;
    check("back_to_idle", {29'd0, down_valid, up_ready, busy}, 32'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] d;
    int a;
    logic dir, arith, rot;

    rst = 1'b1; up_valid = 1'b0; down_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {29'd0, down_valid, up_ready, busy}, 32'd2);
    check("reset_data", 32'(down_data), 32'd0);
    rst = 1'b0;

    // directed cases with hand-derived expectations
    run_op(8'hB6, 5, 1'b0, 1'b0, 1'b0, 8'h05, 3, 0);
    run_op(8'hB6, 2, 1'b0, 1'b1, 1'b0, 8'hED, 2, 1);
    run_op(8'hB6, 9, 1'b0, 1'b1, 1'b0, 8'hFF, 0, 0);
    run_op(8'hB6, 9, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);
    run_op(8'hB6, 3, 1'b1, 1'b0, 1'b0, 8'hB0, 1, 0);
    run_op(8'hB6, 0, 1'b1, 1'b0, 1'b0, 8'hB6, 0, 0);
    run_op(8'hB6, 4, 1'b0, 1'b1, 1'b0, 8'hFB, 2, 5);  // backpressure
`ifdef ITERATIVE_SHIFT_ROTATE_EN
    run_op(8'hB6, 3, 1'b1, 1'b0, 1'b1, 8'hB5, 1, 0);
    run_op(8'hB6, 8, 1'b0, 1'b0, 1'b1, 8'hB6, 0, 0);
`else
    run_op(8'hB6, 3, 1'b1, 1'b0, 1'b1, 8'hB0, 1, 0);
    run_op(8'hB6, 8, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
`endif

    // reset in the second SHIFT cycle of a 5-bit logical right shift
    up_valid = 1'b1; up_data = 8'hB6; up_amount = AW'(5);
    up_dir = 1'b0; up_arith = 1'b0; up_rotate = 1'b0;
    @(posedge clk); #1;
    up_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_flags", {29'd0, down_valid, up_ready, busy}, 32'd2);
    check("midrst_data", 32'(down_data), 32'd0);
    run_op(8'h81, 1, 1'b0, 1'b0, 1'b0, 8'h40, 1, 0);

    // randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      d     = N'($urandom);
      a     = int'($urandom_range(0, (1 << AW) - 1));
      dir   = 1'($urandom);
      arith = 1'($urandom);
      rot   = 1'($urandom);
      run_op(d, a, dir, arith, rot, model_data(d, a, dir, arith, rot),
             model_lat(a, rot), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
